spi_slave_regctl: RTL and testbench
===================================

# spi_slave_regctl

Register-file controller behind the byte-level SPI slave core. Decodes the first byte of each CS_N frame as a command (read/write plus address), then streams bytes into or out of a small register bank, with auto-increment. Supplies `txd_data` to the core and exposes the bank to the system side. Provides a local write port that shares the bank with the SPI side under fixed priority.

## Interface
- `AW`, default 3: register address width; bank depth is `NREG = 1<<AW`, with a legal range of 1..7.
- `RST_VAL`, default 8'h00: reset value of every register.

- `clk`  in  1  system clock, same clock as the SPI slave core.
- `rst`  in  1  asynchronous, active-high reset.
- `cs_n`  in  1  raw SPI chip select, asynchronous to `clk`. It is synchronized internally with 2 flops.
- `rxd_data`  in  8  received byte from the slave core.
- `rxd_flag`  in  1  one-`clk` pulse per completed received byte.
- `txd_data`  out  8  byte the slave core shifts out on the next byte slot.
- `loc_we`  in  1  local write request, single cycle.
- `loc_addr`  in  AW  local write address.
- `loc_wdata`  in  8  local write data.
- `loc_drop`  out  1  one-cycle pulse when a local write is discarded because of a collision.
- `reg_q`  out  8*NREG  flat register bank; register i occupies bits [8i+7:8i].
- `wr_pulse`  out  1  one-cycle pulse for each SPI-side register write.
- `wr_addr`  out  AW  address that accompanies `wr_pulse`.
- `cmd_err`  out  1  one-cycle pulse when a command byte carries an illegal address.

## Operation
- Call the synchronized chip select `cs_s`. Its falling edge starts a frame and its rising edge ends one.
- The FSM has five states: IDLE, CMD, WR, RD, ERR.
  - IDLE to CMD on a `cs_s` falling edge.
  - In CMD, the first `rxd_flag` latches the command byte: `rxd_data[7]` is 1 for read and 0 for write, and `rxd_data[6:0]` is the address.
  - If any of `rxd_data[6:AW]` is nonzero: go to ERR, pulse `cmd_err`, and drive `txd_data` to 8'hFF.
  - On a legal write command: go to WR with `ptr = addr`.
  - On a legal read command: go to RD, set `txd_data <= reg[addr]` and `ptr = addr+1`.
- In WR, each `rxd_flag` does the following:
  - `reg[ptr] <= rxd_data`;
  - `wr_pulse` = 1 and `wr_addr` = ptr;
  - `ptr` increments.
- In RD, each `rxd_flag` sets `txd_data <= reg[ptr]` and increments `ptr`. The received bytes themselves are ignored.
- ERR ignores all bytes and holds `txd_data` at 8'hFF.
- A `cs_s` rising edge returns the FSM from any state to IDLE in the next cycle. This aborts the frame. Writes already committed stay committed.
- The pointer is AW bits wide and wraps modulo NREG (for example 7 to 0 at AW=3).
- Local port: when `loc_we` is high, `reg[loc_addr] <= loc_wdata`.
  - A local write is accepted in any state.
  - If an SPI write hits the same address in the same cycle, the SPI write wins and `loc_drop` pulses.
  - If the addresses differ, both writes commit.
- `wr_pulse` is generated by SPI-side writes only.

## Timing
- Reset values:
  - FSM in IDLE;
  - `ptr` = 0;
  - `txd_data` = 8'h00;
  - every register = `RST_VAL`;
  - `loc_drop`, `wr_pulse`, `cmd_err` = 0;
  - `wr_addr` = 0;
  - the `cs_n` synchronizer flops are preset to 1.
- `cs_n` to `cs_s` latency is 2 `clk` cycles. Frame start/end detection adds 1 more cycle.
- A register write is visible on `reg_q` 1 cycle after `rxd_flag` (SPI) or after `loc_we` (local).
- `txd_data` updates 1 cycle after `rxd_flag`. The core must sample it no earlier than the first SCK edge of the next byte. At 20 ns `clk` and 2 µs SCK period the margin is about 98 cycles.
- `wr_pulse`, `wr_addr` and `cmd_err` are registered and asserted 1 cycle after the triggering `rxd_flag`.
- A `rxd_flag` in the same cycle as a `cs_s` rise is still processed. The transition to IDLE follows in the next cycle.
- A `rxd_flag` while in IDLE is ignored.
- Asserting `rst` mid-frame immediately returns all state to reset values. The frame resumes only at the next `cs_s` fall.

## Configuration
- `SPI_REGCTL_AUTOINC_EN` defined: `ptr` increments after every data byte as described above.
- `SPI_REGCTL_AUTOINC_EN` undefined:
  - `ptr` stays at the command address for the whole frame;
  - repeated writes overwrite the same register;
  - repeated reads return the same register;
  - in RD, `txd_data` is reloaded each byte so that local updates are visible.

## Test plan
- **Write burst:** send frame 8'h02, 8'hA1, 8'hB2 → `reg[2]`=A1 and `reg[3]`=B2; `wr_pulse` twice, with `wr_addr` 2 then 3.
- **Read with wrap:** preload `reg[7]`=5C and `reg[0]`=3D, then send frame 8'h87, xx, xx → `txd_data` = 5C after the command byte and 3D after the first data byte.
- **Illegal address:** send 8'h10 at AW=3 → `cmd_err` pulses once, `txd_data`=FF, no writes for the rest of the frame.
- **Collision:** issue SPI write to `reg[4]`=11 and `loc_we` to address 4 with 22 in the same cycle → `reg[4]`=11 and `loc_drop`=1. Repeat with local address 5 → `reg[5]`=22 and `loc_drop`=0.
- **Abort and reset:** raise `cs_n` after the command byte 8'h01 → FSM back in IDLE, the next frame starts in CMD. Then assert `rst` mid-WR → all registers = `RST_VAL` and `txd_data`=00.
- **Macro off:** with `SPI_REGCTL_AUTOINC_EN` undefined, send frame 8'h03, 8'h01, 8'h02 → `reg[3]`=02 and `reg[4]` unchanged.

Source files
------------

// File: rtl/spi_slave_regctl.sv
// spi_slave_regctl: register-file controller sitting behind a byte-level SPI slave core.
// The first byte of each chip-select frame is a command: bit 7 selects read (1) or write (0),
// and bits 6:0 carry the register address. The bytes that follow stream into or out of the
// register bank.
// A local write port shares the bank with the SPI side. When both hit the same register in
// the same cycle, the SPI write wins.
// Optional feature macro: SPI_REGCTL_AUTOINC_EN. When it is defined, the pointer
// auto-increments after every data byte. When it is undefined, the pointer stays on the
// command address for the whole frame.
module spi_slave_regctl #(
    parameter int         AW      = 3,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs_n,
    input  logic [7:0]              rxd_data,
    input  logic                    rxd_flag,
    output logic [7:0]              txd_data,
    input  logic                    loc_we,
    input  logic [AW-1:0]           loc_addr,
    input  logic [7:0]              loc_wdata,
    output logic                    loc_drop,
    output logic [8*(1<<AW)-1:0]    reg_q,
    output logic                    wr_pulse,
    output logic [AW-1:0]           wr_addr,
    output logic                    cmd_err
);

    localparam int NREG = 1 << AW;

`ifdef SPI_REGCTL_AUTOINC_EN
    localparam logic [AW-1:0] PTR_STEP = AW'(1);
`else
    localparam logic [AW-1:0] PTR_STEP = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD,
        S_ERR
    } state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [7:0]      bank [NREG];

    logic            cs_meta;
    logic            cs_s;
    logic            cs_s_d;
    logic            cs_fall;
    logic            cs_rise;

    logic [6:0]      cmd_hi;
    logic            cmd_bad;
    logic [AW-1:0]   cmd_addr;
    logic            spi_we;

    // Two-flop synchronizer for the raw chip select, plus one delayed copy for edge detection.
    // All three flops idle high so that reset never looks like a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
            cs_s_d  <= 1'b1;
        end else begin
            cs_meta <= cs_n;
            cs_s    <= cs_meta;
            cs_s_d  <= cs_s;
        end
    end

    assign cs_fall  = cs_s_d & ~cs_s;
    assign cs_rise  = ~cs_s_d & cs_s;

    // Any address bit at or above AW makes the command illegal.
    assign cmd_hi   = rxd_data[6:0] >> AW;
    assign cmd_bad  = (cmd_hi != 7'd0);
    assign cmd_addr = rxd_data[AW-1:0];
    assign spi_we   = (state == S_WR) && rxd_flag;

    // Register bank: the SPI write takes priority; a colliding local write is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= RST_VAL;
            end
            loc_drop <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (spi_we && (ptr == AW'(i))) begin
                    bank[i] <= rxd_data;
                end else if (loc_we && (loc_addr == AW'(i))) begin
                    bank[i] <= loc_wdata;
                end
            end
            loc_drop <= loc_we && spi_we && (loc_addr == ptr);
        end
    end

    // Frame FSM: decodes the command, steps the pointer, and drives txd_data and the status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            txd_data <= 8'h00;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            cmd_err  <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cs_fall) begin
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (rxd_flag) begin
                        if (cmd_bad) begin
                            state    <= S_ERR;
                            cmd_err  <= 1'b1;
                            txd_data <= 8'hFF;
                        end else if (rxd_data[7]) begin
                            state    <= S_RD;
                            txd_data <= bank[cmd_addr];
                            ptr      <= cmd_addr + PTR_STEP;
                        end else begin
                            state    <= S_WR;
                            ptr      <= cmd_addr;
                        end
                    end
                end
                S_WR: begin
                    if (rxd_flag) begin
                        wr_pulse <= 1'b1;
                        wr_addr  <= ptr;
                        ptr      <= ptr + PTR_STEP;
                    end
                end
                S_RD: begin
                    if (rxd_flag) begin
                        txd_data <= bank[ptr];
                        ptr      <= ptr + PTR_STEP;
                    end
                end
                S_ERR: begin
                    txd_data <= 8'hFF;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // The end of the frame overrides whatever the state logic chose.
            // A byte arriving in the same cycle has already been processed above.
            if (cs_rise) begin
                state <= S_IDLE;
            end
        end
    end

    // Flatten the bank onto the system-side output bus.
    for (genvar g = 0; g < NREG; g++) begin : g_regq
        assign reg_q[8*g +: 8] = bank[g];
    end

endmodule

// File: tb/tb_spi_slave_regctl.sv
// tb_spi_slave_regctl: directed scoreboard bench for spi_slave_regctl with AW=3.
// A transaction-level model predicts each byte's effects. The predictions are queued when a
// byte is driven and are compared after the following clock edge. Expectations follow
// SPI_REGCTL_AUTOINC_EN, so the same bench serves both builds.
module tb_spi_slave_regctl;

    localparam int         AW      = 3;
    localparam int         NREG    = 8;
    localparam logic [7:0] RST_VAL = 8'h00;

`ifdef SPI_REGCTL_AUTOINC_EN
    localparam logic [2:0] STEP = 3'd1;
`else
    localparam logic [2:0] STEP = 3'd0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cs_n;
    logic [7:0]        rxd_data;
    logic              rxd_flag;
    logic [7:0]        txd_data;
    logic              loc_we;
    logic [AW-1:0]     loc_addr;
    logic [7:0]        loc_wdata;
    logic              loc_drop;
    logic [8*NREG-1:0] reg_q;
    logic              wr_pulse;
    logic [AW-1:0]     wr_addr;
    logic              cmd_err;

    spi_slave_regctl #(.AW(AW), .RST_VAL(RST_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .rxd_data  (rxd_data),
        .rxd_flag  (rxd_flag),
        .txd_data  (txd_data),
        .loc_we    (loc_we),
        .loc_addr  (loc_addr),
        .loc_wdata (loc_wdata),
        .loc_drop  (loc_drop),
        .reg_q     (reg_q),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .cmd_err   (cmd_err)
    );

    // Free-running system clock.
    always #10 clk = ~clk;

    typedef enum {M_IDLE, M_CMD, M_WR, M_RD, M_ERR} mstate_t;

    typedef struct {
        string      tag;
        logic [7:0] txd;
        logic       wrp;
        logic [2:0] wra;
        logic       cerr;
        logic       drop;
        logic [63:0] regq;
    } exp_t;

    exp_t       sb[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    mstate_t    m_state;
    logic [2:0] m_ptr;
    logic [7:0] m_txd;
    logic [7:0] m_bank [NREG];

    function automatic logic [63:0] modelRegq();
        logic [63:0] v;
        for (int i = 0; i < NREG; i++) begin
            v[8*i +: 8] = m_bank[i];
        end
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) begin
            m_bank[i] = RST_VAL;
        end
        m_state = M_IDLE;
        m_ptr   = 3'd0;
        m_txd   = 8'h00;
    endtask

    task automatic compareVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        compareVal({e.tag, ".txd"},  txd_data, e.txd);
        compareVal({e.tag, ".wrp"},  wr_pulse, e.wrp);
        if (e.wrp) begin
            compareVal({e.tag, ".wra"}, wr_addr, e.wra);
        end
        compareVal({e.tag, ".cerr"}, cmd_err,  e.cerr);
        compareVal({e.tag, ".drop"}, loc_drop, e.drop);
        compareVal({e.tag, ".regq"}, reg_q,    e.regq);
    endtask

    // Drive one cycle of inputs, predict the result, then check it after the clock edge.
    task automatic applyStimulus(input string tag, input logic flag, input logic [7:0] data,
                                 input logic lwe, input logic [2:0] la, input logic [7:0] lwd);
        exp_t       e;
        logic       spi_wr;
        logic [2:0] spi_a;
        @(negedge clk);
        rxd_flag  = flag;
        rxd_data  = data;
        loc_we    = lwe;
        loc_addr  = la;
        loc_wdata = lwd;
        e.tag  = tag;
        e.wrp  = 1'b0;
        e.wra  = 3'd0;
        e.cerr = 1'b0;
        e.drop = 1'b0;
        spi_wr = 1'b0;
        spi_a  = m_ptr;
        if (flag) begin
            case (m_state)
                M_CMD: begin
                    if (data[6:3] != 4'd0) begin
                        m_state = M_ERR;
                        e.cerr  = 1'b1;
                        m_txd   = 8'hFF;
                    end else if (data[7]) begin
                        m_state = M_RD;
                        m_txd   = m_bank[data[2:0]];
                        m_ptr   = data[2:0] + STEP;
                    end else begin
                        m_state = M_WR;
                        m_ptr   = data[2:0];
                    end
                end
                M_WR: begin
                    spi_wr         = 1'b1;
                    spi_a          = m_ptr;
                    m_bank[m_ptr]  = data;
                    e.wrp          = 1'b1;
                    e.wra          = m_ptr;
                    m_ptr          = m_ptr + STEP;
                end
                M_RD: begin
                    m_txd = m_bank[m_ptr];
                    m_ptr = m_ptr + STEP;
                end
                M_ERR: m_txd = 8'hFF;
                default: ;
            endcase
        end
        if (lwe) begin
            if (spi_wr && (spi_a == la)) begin
                e.drop = 1'b1;
            end else begin
                m_bank[la] = lwd;
            end
        end
        e.txd  = m_txd;
        e.regq = modelRegq();
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        rxd_flag = 1'b0;
        loc_we   = 1'b0;
        checkOutput();
    endtask

    task automatic sendByte(input string tag, input logic [7:0] data);
        applyStimulus(tag, 1'b1, data, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic localWrite(input string tag, input logic [2:0] la, input logic [7:0] lwd);
        applyStimulus(tag, 1'b0, 8'h00, 1'b1, la, lwd);
    endtask

    task automatic startFrame();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(posedge clk);
        m_state = M_CMD;
    endtask

    task automatic endFrame();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        m_state = M_IDLE;
    endtask

    // Watchdog so the run always ends even if the bench stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence covering reset, bursts, wrap, errors, collisions, abort and reset.
    initial begin
        rst       = 1'b1;
        cs_n      = 1'b1;
        rxd_data  = 8'h00;
        rxd_flag  = 1'b0;
        loc_we    = 1'b0;
        loc_addr  = 3'd0;
        loc_wdata = 8'h00;
        modelReset();
        repeat (2) @(negedge clk);
        compareVal("reset.txd",  txd_data, 8'h00);
        compareVal("reset.wrp",  wr_pulse, 1'b0);
        compareVal("reset.wra",  wr_addr,  3'd0);
        compareVal("reset.cerr", cmd_err,  1'b0);
        compareVal("reset.drop", loc_drop, 1'b0);
        compareVal("reset.regq", reg_q,    {NREG{RST_VAL}});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write burst
        startFrame();
        sendByte("wb.cmd", 8'h02);
        sendByte("wb.d0",  8'hA1);
        sendByte("wb.d1",  8'hB2);
        endFrame();

        // Read with wrap
        localWrite("rw.pre7", 3'd7, 8'h5C);
        localWrite("rw.pre0", 3'd0, 8'h3D);
        startFrame();
        sendByte("rw.cmd", 8'h87);
        sendByte("rw.d0",  8'h00);
        sendByte("rw.d1",  8'h00);
        endFrame();

        // Illegal address
        startFrame();
        sendByte("ill.cmd", 8'h10);
        sendByte("ill.d0",  8'h55);
        sendByte("ill.d1",  8'h66);
        endFrame();

        // Collision on same address, then different addresses
        startFrame();
        sendByte("col.cmd", 8'h04);
        applyStimulus("col.same", 1'b1, 8'h11, 1'b1, 3'd4, 8'h22);
        endFrame();
        startFrame();
        sendByte("col2.cmd", 8'h04);
        applyStimulus("col.diff", 1'b1, 8'h11, 1'b1, 3'd5, 8'h22);
        endFrame();

        // Abort after command, byte in IDLE ignored, next frame decodes normally
        startFrame();
        sendByte("ab.cmd", 8'h01);
        endFrame();
        sendByte("ab.idle", 8'h99);
        startFrame();
        sendByte("ab.cmd2", 8'h06);
        sendByte("ab.d0",   8'h77);

        // Reset mid-WR
        @(negedge clk);
        rst  = 1'b1;
        cs_n = 1'b1;
        #1;
        compareVal("rst.regq", reg_q,    {NREG{RST_VAL}});
        compareVal("rst.txd",  txd_data, 8'h00);
        compareVal("rst.wrp",  wr_pulse, 1'b0);
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        sendByte("rst.idle", 8'h42);

        // Pointer behaviour with repeated bytes (autoinc build vs. fixed pointer build)
        startFrame();
        sendByte("mo.cmd", 8'h03);
        sendByte("mo.d0",  8'h01);
        sendByte("mo.d1",  8'h02);
        endFrame();

        tests_run++;
        assert (sb.size() === 0) else begin
            tests_failed++;
            $error("[TB] FAIL sb.drain: observed %0d expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
